// File: rtl/iob_axis_s_axi_m_write_cmd.sv
// Splits a long word-count write request into bursts of at most 2^AXI_LEN_W words.
// Each burst is handed to a downstream AXIS-to-AXI write engine, one burst at a time.
module iob_axis_s_axi_m_write_cmd #(
  parameter int AXI_ADDR_W  = 32,
  parameter int AXI_LEN_W   = 8,
  parameter int TOTAL_LEN_W = 20
) (
  input  logic                   clk_i,
  input  logic                   cke_i,
  input  logic                   arst_n_i,
  input  logic                   start_i,
  input  logic [AXI_ADDR_W-1:0]  addr_i,
  input  logic [TOTAL_LEN_W-1:0] length_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [TOTAL_LEN_W-1:0] burst_cnt_o,
  output logic                   w_start_transfer_o,
  output logic [AXI_ADDR_W-1:0]  w_addr_o,
  output logic [AXI_LEN_W:0]     w_length_o,
  input  logic                   w_busy_i
);

  localparam int MAX_BURST = 2 ** AXI_LEN_W;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;

  state_t                 state_q, state_d;
  logic [AXI_ADDR_W-1:0]  cur_addr_q, cur_addr_d;
  logic [TOTAL_LEN_W-1:0] remaining_q, remaining_d;
  logic [TOTAL_LEN_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [AXI_ADDR_W-1:0]  w_addr_q, w_addr_d;
  logic [AXI_LEN_W:0]     w_length_q, w_length_d;

  function automatic logic [AXI_LEN_W:0] clip_len(input logic [TOTAL_LEN_W-1:0] n);
    if (n >= TOTAL_LEN_W'(MAX_BURST)) return (AXI_LEN_W+1)'(MAX_BURST);
    else return n[AXI_LEN_W:0];
  endfunction

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      burst_cnt_q <= '0;
      w_addr_q    <= '0;
      w_length_q  <= '0;
    end else if (cke_i) begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      burst_cnt_q <= burst_cnt_d;
      w_addr_q    <= w_addr_d;
      w_length_q  <= w_length_d;
    end
  end

  // Burst address/length are loaded on entry to ISSUE so they are already valid with the pulse.
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    burst_cnt_d = burst_cnt_q;
    w_addr_d    = w_addr_q;
    w_length_d  = w_length_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          burst_cnt_d = '0;
          if (length_i != '0) begin
            cur_addr_d  = addr_i;
            remaining_d = length_i;
            w_addr_d    = addr_i;
            w_length_d  = clip_len(length_i);
            state_d     = ISSUE;
          end else begin
            state_d = FINISH;
          end
        end
      end
      ISSUE: begin
        cur_addr_d  = cur_addr_q + (AXI_ADDR_W'(w_length_q) << 2);
        remaining_d = remaining_q - TOTAL_LEN_W'(w_length_q);
        burst_cnt_d = burst_cnt_q + 1'b1;
        state_d     = WAIT;
      end
      WAIT: begin
        if (!w_busy_i) begin
          if (remaining_q != '0) begin
            w_addr_d   = cur_addr_q;
            w_length_d = clip_len(remaining_q);
            state_d    = ISSUE;
          end else begin
            state_d = FINISH;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_o             = (state_q != IDLE);
  assign done_o             = (state_q == FINISH);
  assign w_start_transfer_o = (state_q == ISSUE);
  assign burst_cnt_o        = burst_cnt_q;
  assign w_addr_o           = w_addr_q;
  assign w_length_o         = w_length_q;

endmodule

// File: tb/tb_iob_axis_s_axi_m_write_cmd.sv
// Scoreboard bench: directed transfers push expected bursts/done events; a negedge monitor checks them.
`timescale 1ns/1ps
module tb_iob_axis_s_axi_m_write_cmd;

  logic        clk = 0;
  logic        cke_i = 1;
  logic        arst_n = 0;
  logic        start_i = 0;
  logic [31:0] addr_i = '0;
  logic [19:0] length_i = '0;
  logic        busy_o, done_o, w_start_transfer_o;
  logic [19:0] burst_cnt_o;
  logic [31:0] w_addr_o;
  logic [8:0]  w_length_o;
  logic        w_busy;

  iob_axis_s_axi_m_write_cmd #(.AXI_ADDR_W(32), .AXI_LEN_W(8), .TOTAL_LEN_W(20)) dut (
    .clk_i(clk), .cke_i(cke_i), .arst_n_i(arst_n), .start_i(start_i),
    .addr_i(addr_i), .length_i(length_i), .busy_o(busy_o), .done_o(done_o),
    .burst_cnt_o(burst_cnt_o), .w_start_transfer_o(w_start_transfer_o),
    .w_addr_o(w_addr_o), .w_length_o(w_length_o), .w_busy_i(w_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    logic [31:0] addr;
    logic [8:0]  len;
    logic [19:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   busy_len = 3;
  int   busy_left;
  int   cyc = 0;
  int   trig = -10;
  logic prev_wbusy = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic void push_burst(input logic [31:0] a, input logic [8:0] l);
    exp_t e;
    e.is_done = 0; e.addr = a; e.len = l; e.cnt = '0;
    exp_q.push_back(e);
  endfunction

  function automatic void push_done(input logic [19:0] c);
    exp_t e;
    e.is_done = 1; e.addr = '0; e.len = '0; e.cnt = c;
    exp_q.push_back(e);
  endfunction

  // Downstream engine model: busy rises on the edge that samples the pulse, stays busy_len cycles.
  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      w_busy    <= 1'b0;
      busy_left <= 0;
    end else if (cke_i) begin
      if (w_start_transfer_o) begin
        busy_left <= busy_len;
        w_busy    <= 1'b1;
      end else if (busy_left > 1) begin
        busy_left <= busy_left - 1;
      end else begin
        busy_left <= 0;
        w_busy    <= 1'b0;
      end
    end
  end

  always @(posedge clk) if (cke_i) cyc <= cyc + 1;

  // Monitor: every event must follow its trigger (accepted start or engine going idle) by one cycle.
  always @(negedge clk) begin
    if (arst_n && cke_i && (w_start_transfer_o || done_o)) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_event start=%0b done=%0b addr=0x%0h len=%0d", w_start_transfer_o, done_o, w_addr_o, w_length_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("event_is_done", {63'd0, done_o}, {63'd0, e.is_done});
        if (e.is_done) begin
          chk("done_burst_cnt", {44'd0, burst_cnt_o}, {44'd0, e.cnt});
        end else begin
          chk("burst_addr", {32'd0, w_addr_o}, {32'd0, e.addr});
          chk("burst_len", {55'd0, w_length_o}, {55'd0, e.len});
        end
        $display("event done=%0b addr=0x%0h len=%0d cnt=%0d cyc=%0d", done_o, w_addr_o, w_length_o, burst_cnt_o, cyc);
        chk("event_latency", 64'(cyc), 64'(trig + 1));
      end
    end
    if (start_i && !busy_o && cke_i && arst_n) trig = cyc;
    if (prev_wbusy && !w_busy) trig = cyc;
    prev_wbusy = w_busy;
  end

  task automatic pulse_start(input logic [31:0] a, input logic [19:0] l);
    @(posedge clk); #1;
    start_i = 1; addr_i = a; length_i = l;
    @(posedge clk); #1;
    start_i = 0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy_o || w_busy || exp_q.size() != 0) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 3000) begin
      checks++; failures++;
      $display("FAIL %s_timeout pending=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_wbusy(input string name);
    int n = 0;
    while (!w_busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      checks++; failures++;
      $display("FAIL %s_wbusy_timeout actual=0 required=1", name);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_busy"}, {63'd0, busy_o}, 64'd0);
    chk({name, "_done"}, {63'd0, done_o}, 64'd0);
    chk({name, "_wstart"}, {63'd0, w_start_transfer_o}, 64'd0);
    chk({name, "_cnt"}, {44'd0, burst_cnt_o}, 64'd0);
    chk({name, "_waddr"}, {32'd0, w_addr_o}, 64'd0);
    chk({name, "_wlen"}, {55'd0, w_length_o}, 64'd0);
  endtask

  initial begin
    #3;
    chk_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 arst_n = 1;

    // Single 16-word burst, engine busy 5 cycles.
    busy_len = 5;
    push_burst(32'h1000, 9'd16); push_done(20'd1);
    pulse_start(32'h1000, 20'd16);
    wait_idle("single");
    chk("single_cnt_hold", {44'd0, burst_cnt_o}, 64'd1);
    chk("single_len_hold", {55'd0, w_length_o}, 64'd16);

    // 600 words split on 256-word bursts.
    busy_len = 3;
    push_burst(32'h0, 9'd256); push_burst(32'h400, 9'd256); push_burst(32'h800, 9'd88); push_done(20'd3);
    pulse_start(32'h0, 20'd600);
    wait_idle("split");

    // Zero length: done only.
    push_done(20'd0);
    pulse_start(32'h3000, 20'd0);
    wait_idle("zero");

    // Exactly one full burst, then a start pulse during WAIT that must be ignored.
    busy_len = 6;
    push_burst(32'h2000, 9'd256); push_burst(32'h2400, 9'd1); push_done(20'd2);
    pulse_start(32'h2000, 20'd257);
    wait_wbusy("ignore");
    pulse_start(32'h5000, 20'd3);
    wait_idle("ignore");

    // Reset during WAIT abandons the rest, then a 4-word transfer completes.
    busy_len = 4;
    push_burst(32'h0, 9'd256); push_burst(32'h400, 9'd256); push_burst(32'h800, 9'd88); push_done(20'd3);
    pulse_start(32'h0, 20'd600);
    wait_wbusy("rst");
    arst_n = 0;
    #1;
    chk_all_zero("midrst");
    chk("midrst_flushed_first", 64'(exp_q.size()), 64'd3);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 arst_n = 1;
    push_burst(32'h300, 9'd4); push_done(20'd1);
    pulse_start(32'h300, 20'd4);
    wait_idle("after_rst");

    // Clock enable low for 10 cycles while in ISSUE.
    busy_len = 2;
    push_burst(32'h4000, 9'd8); push_done(20'd1);
    @(posedge clk); #1;
    start_i = 1; addr_i = 32'h4000; length_i = 20'd8;
    @(posedge clk); #1;
    start_i = 0; cke_i = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("stall_wstart", {63'd0, w_start_transfer_o}, 64'd1);
    end
    chk("stall_waddr", {32'd0, w_addr_o}, 64'h4000);
    chk("stall_cnt", {44'd0, burst_cnt_o}, 64'd0);
    cke_i = 1;
    wait_idle("stall");

    chk("leftover_expected", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
